// File: rtl/spatz_xif_pkg.sv
// spatz_xif_pkg: shared X-interface memory channel types and access-fault codes
package spatz_xif_pkg;
   localparam int unsigned XAddrWidth = 32;
   localparam int unsigned XDataWidth = 32;
   localparam int unsigned XIdWidth   = 4;
   localparam logic [5:0] EXC_LOAD_ACCESS_FAULT  = 6'd5;
   localparam logic [5:0] EXC_STORE_ACCESS_FAULT = 6'd7;
   typedef struct packed {
      logic [XAddrWidth-1:0]   addr;
      logic                    we;
      logic [XDataWidth/8-1:0] be;
      logic [XDataWidth-1:0]   wdata;
      logic [XIdWidth-1:0]     id;
   } x_mem_req_t;
   typedef struct packed {
      logic       exc;
      logic [5:0] exccode;
   } x_mem_resp_t;
   typedef struct packed {
      logic [XDataWidth-1:0] rdata;
      logic [XIdWidth-1:0]   id;
      logic                  err;
   } x_mem_result_t;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: registered-output FIFO; flush_i clears pointers synchronously, DEPTH must be a power of two
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);
   logic [AddrDepth-1:0] rd_q, wr_q;
   logic [AddrDepth:0] cnt_q;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
   logic do_push, do_pop;
   assign full_o  = cnt_q == (AddrDepth+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_q];
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) mem_q[wr_q] <= data_i;
         wr_q  <= wr_q + AddrDepth'(do_push);
         rd_q  <= rd_q + AddrDepth'(do_pop);
         cnt_q <= cnt_q + (AddrDepth+1)'(do_push) - (AddrDepth+1)'(do_pop);
      end
   end
endmodule

// File: rtl/spatz_xif_mem_lane.sv
// spatz_xif_mem_lane: one memory port -- legality check, in-order ID FIFO and registered result
module spatz_xif_mem_lane import spatz_xif_pkg::*; #(
   parameter int unsigned    AddrWidth      = XAddrWidth,
   parameter int unsigned    DataWidth      = XDataWidth,
   parameter int unsigned    IdWidth        = XIdWidth,
   parameter int unsigned    MaxOutstanding = 4,
   parameter logic [AddrWidth-1:0] BaseAddr = 32'h1000_0000,
   parameter logic [AddrWidth-1:0] AddrSpan = 32'h0002_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   x_mem_valid_i,
   output logic                   x_mem_ready_o,
   input  x_mem_req_t             x_mem_req_i,
   output x_mem_resp_t            x_mem_resp_o,
   output logic                   x_mem_result_valid_o,
   output x_mem_result_t          x_mem_result_o,
   output logic                   mem_req_valid_o,
   input  logic                   mem_req_ready_i,
   output logic [AddrWidth-1:0]   mem_req_addr_o,
   output logic                   mem_req_we_o,
   output logic [DataWidth/8-1:0] mem_req_be_o,
   output logic [DataWidth-1:0]   mem_req_wdata_o,
   input  logic                   mem_rsp_valid_i,
   input  logic [DataWidth-1:0]   mem_rsp_rdata_i,
   input  logic                   mem_rsp_err_i,
   output logic                   idle_o
);
   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic               we;
   } tag_t;
   logic legal, full, empty, hs, push, pop, fault;
   logic [AddrWidth:0] addr_ext;
   tag_t head;
   x_mem_result_t result_d, result_q;
   logic result_valid_d, result_valid_q;
   // one extra bit so a window ending at the top of the address space does not wrap
   assign addr_ext = {1'b0, x_mem_req_i.addr};
   assign legal = addr_ext >= {1'b0, BaseAddr} && addr_ext < {1'b0, BaseAddr} + {1'b0, AddrSpan} &&
                  x_mem_req_i.addr[1:0] == 2'b00;
   assign x_mem_ready_o   = !rst_i && !full && (!legal || mem_req_ready_i);
   assign mem_req_valid_o = !rst_i && x_mem_valid_i && legal && !full;
   assign mem_req_addr_o  = x_mem_req_i.addr;
   assign mem_req_we_o    = x_mem_req_i.we;
   assign mem_req_be_o    = x_mem_req_i.be;
   assign mem_req_wdata_o = x_mem_req_i.wdata;
   assign hs    = x_mem_valid_i && x_mem_ready_o;
   assign push  = hs && legal;
   assign fault = hs && !legal;
   assign pop   = !rst_i && mem_rsp_valid_i && !empty;
   assign x_mem_resp_o = '{exc: fault,
                           exccode: fault ? (x_mem_req_i.we ? EXC_STORE_ACCESS_FAULT : EXC_LOAD_ACCESS_FAULT) : 6'd0};
   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   ($bits(tag_t)),
      .DEPTH        (MaxOutstanding)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (1'b1),
      .flush_i (rst_i),
      .full_o  (full),
      .empty_o (empty),
      .data_i  ({x_mem_req_i.id, x_mem_req_i.we}),
      .push_i  (push),
      .data_o  (head),
      .pop_i   (pop)
   );
   assign result_valid_d = pop;
   assign result_d = '{rdata: head.we ? '0 : mem_rsp_rdata_i, id: head.id, err: mem_rsp_err_i};
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_valid_q <= 1'b0;
         result_q       <= '0;
      end else begin
         result_valid_q <= result_valid_d;
         if (pop) result_q <= result_d;
      end
   end
   assign x_mem_result_valid_o = result_valid_q;
   assign x_mem_result_o       = result_q;
   assign idle_o               = empty && !result_valid_q;
   // a response with nothing outstanding is only expected from requests issued before a reset
   always_ff @(posedge clk_i) begin
      if (!rst_i && mem_rsp_valid_i) assert (!empty) else $warning("memory response dropped: no outstanding request");
   end
endmodule

// File: rtl/spatz_xif_mem_responder.sv
// spatz_xif_mem_responder: core-side X-interface memory responder, one independent lane per port
module spatz_xif_mem_responder import spatz_xif_pkg::*; #(
   parameter int unsigned NrMemPorts     = 1,
   parameter int unsigned AddrWidth      = XAddrWidth,
   parameter int unsigned DataWidth      = XDataWidth,
   parameter int unsigned IdWidth        = XIdWidth,
   parameter int unsigned MaxOutstanding = 4,
   parameter logic [AddrWidth-1:0] BaseAddr = 32'h1000_0000,
   parameter logic [AddrWidth-1:0] AddrSpan = 32'h0002_0000,
   localparam int unsigned BeWidth = DataWidth / 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic          [NrMemPorts-1:0]                 x_mem_valid_i,
   output logic          [NrMemPorts-1:0]                 x_mem_ready_o,
   input  x_mem_req_t    [NrMemPorts-1:0]                 x_mem_req_i,
   output x_mem_resp_t   [NrMemPorts-1:0]                 x_mem_resp_o,
   output logic          [NrMemPorts-1:0]                 x_mem_result_valid_o,
   output x_mem_result_t [NrMemPorts-1:0]                 x_mem_result_o,
   output logic          [NrMemPorts-1:0]                 mem_req_valid_o,
   input  logic          [NrMemPorts-1:0]                 mem_req_ready_i,
   output logic          [NrMemPorts-1:0][AddrWidth-1:0]  mem_req_addr_o,
   output logic          [NrMemPorts-1:0]                 mem_req_we_o,
   output logic          [NrMemPorts-1:0][BeWidth-1:0]    mem_req_be_o,
   output logic          [NrMemPorts-1:0][DataWidth-1:0]  mem_req_wdata_o,
   input  logic          [NrMemPorts-1:0]                 mem_rsp_valid_i,
   input  logic          [NrMemPorts-1:0][DataWidth-1:0]  mem_rsp_rdata_i,
   input  logic          [NrMemPorts-1:0]                 mem_rsp_err_i,
   output logic                                  idle_o
);
   logic [NrMemPorts-1:0] lane_idle;
   for (genvar i = 0; i < NrMemPorts; i++) begin : g_lane
      spatz_xif_mem_lane #(
         .AddrWidth      (AddrWidth),
         .DataWidth      (DataWidth),
         .IdWidth        (IdWidth),
         .MaxOutstanding (MaxOutstanding),
         .BaseAddr       (BaseAddr),
         .AddrSpan       (AddrSpan)
      ) i_lane (
         .clk_i                (clk_i),
         .rst_i                (rst_i),
         .x_mem_valid_i        (x_mem_valid_i[i]),
         .x_mem_ready_o        (x_mem_ready_o[i]),
         .x_mem_req_i          (x_mem_req_i[i]),
         .x_mem_resp_o         (x_mem_resp_o[i]),
         .x_mem_result_valid_o (x_mem_result_valid_o[i]),
         .x_mem_result_o       (x_mem_result_o[i]),
         .mem_req_valid_o      (mem_req_valid_o[i]),
         .mem_req_ready_i      (mem_req_ready_i[i]),
         .mem_req_addr_o       (mem_req_addr_o[i]),
         .mem_req_we_o         (mem_req_we_o[i]),
         .mem_req_be_o         (mem_req_be_o[i]),
         .mem_req_wdata_o      (mem_req_wdata_o[i]),
         .mem_rsp_valid_i      (mem_rsp_valid_i[i]),
         .mem_rsp_rdata_i      (mem_rsp_rdata_i[i]),
         .mem_rsp_err_i        (mem_rsp_err_i[i]),
         .idle_o               (lane_idle[i])
      );
   end
   assign idle_o = &lane_idle;
endmodule

// File: tb/tb_spatz_xif_mem_responder.sv
// tb_spatz_xif_mem_responder: directed scenarios plus random traffic against a queue-based reference model
module tb_spatz_xif_mem_responder;
   import spatz_xif_pkg::*;
   localparam logic [31:0] Base = 32'h1000_0000;
   localparam logic [31:0] Span = 32'h0002_0000;
   localparam int Depth = 4;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic [0:0] x_mem_valid_i, x_mem_ready_o, x_mem_result_valid_o, mem_req_valid_o, mem_req_ready_i;
   logic [0:0] mem_req_we_o, mem_rsp_valid_i, mem_rsp_err_i;
   x_mem_req_t    [0:0] x_mem_req_i;
   x_mem_resp_t   [0:0] x_mem_resp_o;
   x_mem_result_t [0:0] x_mem_result_o;
   logic [0:0][31:0] mem_req_addr_o, mem_req_wdata_o, mem_rsp_rdata_i;
   logic [0:0][3:0] mem_req_be_o;
   logic idle_o;
   always #5 clk_i = ~clk_i;
   spatz_xif_mem_responder #(
      .NrMemPorts(1), .AddrWidth(32), .DataWidth(32), .IdWidth(4), .MaxOutstanding(Depth),
      .BaseAddr(Base), .AddrSpan(Span)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o), .x_mem_req_i(x_mem_req_i),
      .x_mem_resp_o(x_mem_resp_o), .x_mem_result_valid_o(x_mem_result_valid_o), .x_mem_result_o(x_mem_result_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
      .mem_req_we_o(mem_req_we_o), .mem_req_be_o(mem_req_be_o), .mem_req_wdata_o(mem_req_wdata_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i), .mem_rsp_err_i(mem_rsp_err_i),
      .idle_o(idle_o)
   );
   typedef struct {
      logic [3:0] id;
      logic       we;
   } ent_t;
   ent_t fifo_m[$];
   int mem_q[$];
   int cyc, n_pass, n_chk;
   logic exp_rv = 1'b0;
   logic [31:0] exp_rd;
   logic [3:0] exp_id;
   logic exp_err;
   logic dummy;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask
   function automatic logic legal(input logic [31:0] a);
      longint ua = longint'(a);
      return ua >= longint'(Base) && ua < longint'(Base) + longint'(Span) && a[1:0] == 2'b00;
   endfunction
   task automatic step(input logic v, input logic [31:0] a, input logic w, input logic [3:0] i, input logic [31:0] wd,
                       input logic mr, input logic rv, input logic [31:0] rd, input logic re, output logic acc);
      logic lg, full, rdy;
      ent_t e;
      chk("result_valid", x_mem_result_valid_o[0], exp_rv);
      if (exp_rv) begin
         chk("result_rdata", x_mem_result_o[0].rdata, exp_rd);
         chk("result_id", x_mem_result_o[0].id, exp_id);
         chk("result_err", x_mem_result_o[0].err, exp_err);
      end
      chk("idle", idle_o, fifo_m.size() == 0 && !exp_rv);
      x_mem_valid_i[0] = v;
      x_mem_req_i[0] = '{addr: a, we: w, be: wd[31:28], wdata: wd, id: i};
      mem_req_ready_i[0] = mr;
      mem_rsp_valid_i[0] = rv;
      mem_rsp_rdata_i[0] = rd;
      mem_rsp_err_i[0] = re;
      #1;
      lg = legal(a);
      full = fifo_m.size() == Depth;
      rdy = !full && (!lg || mr);
      chk("ready", x_mem_ready_o[0], rdy);
      chk("mem_req_valid", mem_req_valid_o[0], v && lg && !full);
      if (v && lg && !full) begin
         chk("mem_req_addr", mem_req_addr_o[0], a);
         chk("mem_req_we", mem_req_we_o[0], w);
         chk("mem_req_be", mem_req_be_o[0], wd[31:28]);
         chk("mem_req_wdata", mem_req_wdata_o[0], wd);
      end
      if (v && rdy) begin
         chk("resp_exc", x_mem_resp_o[0].exc, !lg);
         chk("resp_exccode", x_mem_resp_o[0].exccode, lg ? 0 : (w ? 7 : 5));
      end
      acc = v && rdy && lg;
      @(posedge clk_i);
      cyc++;
      exp_rv = rv && fifo_m.size() > 0;
      if (exp_rv) begin
         e = fifo_m.pop_front();
         exp_rd = e.we ? 32'd0 : rd;
         exp_id = e.id;
         exp_err = re;
      end
      if (acc) fifo_m.push_back('{i, w});
      #1;
   endtask
   // memory model: in-order responses, 1..3 cycles after acceptance
   task automatic mstep(input logic v, input logic [31:0] a, input logic w, input logic [3:0] i, input logic mr);
      logic rv, acc;
      rv = mem_q.size() > 0 && mem_q[0] <= cyc;
      step(v, a, w, i, $urandom, mr, rv, $urandom, $urandom_range(0, 9) == 0, acc);
      if (rv) void'(mem_q.pop_front());
      if (acc) mem_q.push_back(cyc - 1 + int'($urandom_range(1, 3)));
   endtask
   task automatic do_reset();
      rst_i = 1'b1;
      x_mem_valid_i[0] = 1'b1;
      x_mem_req_i[0] = '{addr: Base, we: 1'b0, be: 4'hF, wdata: 32'h0, id: 4'h1};
      mem_req_ready_i[0] = 1'b1;
      mem_rsp_valid_i[0] = 1'b0;
      mem_rsp_err_i[0] = 1'b0;
      mem_rsp_rdata_i[0] = 32'h0;
      #1;
      chk("rst_ready", x_mem_ready_o[0], 0);
      chk("rst_mem_valid", mem_req_valid_o[0], 0);
      chk("rst_resp", x_mem_resp_o[0], 0);
      repeat (2) @(posedge clk_i);
      cyc += 2;
      #1;
      rst_i = 1'b0;
      x_mem_valid_i[0] = 1'b0;
      fifo_m.delete();
      exp_rv = 1'b0;
      chk("rst_result_valid", x_mem_result_valid_o[0], 0);
      chk("rst_result_rdata", x_mem_result_o[0].rdata, 0);
      chk("rst_result_id_err", {x_mem_result_o[0].id, x_mem_result_o[0].err}, 0);
      chk("rst_idle", idle_o, 1);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end
   initial begin
      logic [31:0] edge_addr [6];
      logic [31:0] a;
      edge_addr = '{Base - 32'd4, Base + Span, Base + Span - 32'd4, Base + 32'd1, 32'hFFFF_FFFC, Base + Span - 32'd2};
      do_reset();
      // load, response two cycles after acceptance
      step(1, Base, 0, 4'd3, 32'h0, 1, 0, 0, 0, dummy);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, dummy);
      step(0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, dummy);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, dummy);
      // illegal and boundary addresses
      step(1, 32'h1002_0000, 1, 4'd5, 32'h1234_5678, 1, 0, 0, 0, dummy);
      step(1, 32'h1000_0002, 0, 4'd6, 32'h0, 1, 0, 0, 0, dummy);
      step(1, 32'h0FFF_FFFC, 0, 4'd6, 32'h0, 1, 0, 0, 0, dummy);
      step(1, 32'hFFFF_FFFC, 1, 4'd6, 32'h0, 1, 0, 0, 0, dummy);
      step(1, 32'h1001_FFFC, 0, 4'd8, 32'h0, 1, 0, 0, 0, dummy);
      step(0, 0, 0, 0, 0, 1, 1, 32'h0BAD_CAFE, 0, dummy);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, dummy);
      // back-pressure: four outstanding, fifth held until a pop
      for (int k = 0; k < 4; k++) step(1, Base + 32'(k * 4), 0, 4'(k), 0, 1, 0, 0, 0, dummy);
      step(1, Base + 32'h10, 0, 4'd4, 0, 1, 0, 0, 0, dummy);
      step(1, 32'h1000_0001, 0, 4'd4, 0, 1, 0, 0, 0, dummy);
      step(1, Base + 32'h10, 0, 4'd4, 0, 1, 1, 32'h1111_0000, 0, dummy);
      step(1, Base + 32'h10, 0, 4'd4, 0, 1, 0, 0, 0, dummy);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 1, 32'h2222_0000 + 32'(k), 0, dummy);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, dummy);
      // push and pop together at count 3, then fill to full, with a bus error
      for (int k = 0; k < 3; k++) step(1, Base + 32'h100, k == 1, 4'(8 + k), 32'hA5A5_0000, 1, 0, 0, 0, dummy);
      step(1, Base + 32'h104, 0, 4'd11, 0, 1, 1, 32'h3333_3333, 1, dummy);
      step(1, Base + 32'h108, 0, 4'd12, 0, 1, 0, 0, 0, dummy);
      step(1, Base + 32'h10C, 0, 4'd13, 0, 1, 0, 0, 0, dummy);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 1, 32'h4444_0000 + 32'(k), k == 2, dummy);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, dummy);
      // reset with three outstanding, stale responses afterwards
      for (int k = 0; k < 3; k++) step(1, Base + 32'h200, 0, 4'(k), 0, 1, 0, 0, 0, dummy);
      do_reset();
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, 1, 32'h5555_0000, 0, dummy);
      step(1, Base + 32'h300, 0, 4'd14, 0, 1, 0, 0, 0, dummy);
      step(0, 0, 0, 0, 0, 1, 1, 32'h6666_6666, 0, dummy);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, dummy);
      // ordering: ids 7, 2 (store), 9 with varying latency
      mstep(1, Base + 32'h10, 0, 4'd7, 1);
      mstep(1, Base + 32'h20, 1, 4'd2, 1);
      mstep(1, Base + 32'h30, 0, 4'd9, 1);
      for (int k = 0; k < 20 && (mem_q.size() > 0 || exp_rv); k++) mstep(0, 0, 0, 0, 1);
      chk("order_drain", mem_q.size(), 0);
      // random traffic
      for (int n = 0; n < 400; n++) begin
         a = $urandom_range(0, 9) < 7 ? Base + ($urandom_range(0, Span / 4 - 1) << 2) : edge_addr[$urandom_range(0, 5)];
         mstep($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 4) != 0);
      end
      for (int k = 0; k < 50 && (mem_q.size() > 0 || exp_rv); k++) mstep(0, 0, 0, 0, 1);
      chk("random_drain", mem_q.size(), 0);
      chk("final_idle", idle_o, fifo_m.size() == 0 && !exp_rv);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
